// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, the
// default frame width and a constant-foldable ceil(log2) helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DBIT_DEFAULT = 8;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first asserted request
// after last_gnt, wrapping modulo NREQ. Lowest priority goes to last_gnt.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last_gnt,
    output logic [NREQ-1:0]        gnt,
    output logic [clog2(NREQ)-1:0] gnt_idx
);

    localparam int IDXW = clog2(NREQ);

    // Scan last_gnt+1, last_gnt+2, ... and stop at the first set bit
    always_comb begin : pick
        logic            found;
        logic [IDXW-1:0] idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional logic, otherwise a path that skips the assignment
        // makes synthesis hold the old value in a latch.
        gnt     = '0;
        gnt_idx = last_gnt;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDXW'((int'(last_gnt) + i) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ producers.
// Grants a byte, pulses tx_start, waits for tx_done_tick (or a timeout
// counted in s_tick pulses) and then holds an inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int DBIT          = DBIT_DEFAULT,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 320
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int IDXW    = clog2(NREQ);
    localparam int CNT_TOP = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = (clog2(CNT_TOP + 1) < 1) ? 1 : clog2(CNT_TOP + 1);

    // A finished (or aborted) frame skips the gap entirely when it is zero
    localparam state_e DONE_NEXT = (GAP_TICKS == 0) ? IDLE : GAP;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [IDXW-1:0]  last_gnt_q,    last_gnt_d;
    logic [NREQ-1:0]  ack_q,         ack_d;
    logic             tx_start_q,    tx_start_d;
    logic [DBIT-1:0]  tx_din_q,      tx_din_d;
    logic             busy_q,        busy_d;
    logic             err_timeout_q, err_timeout_d;

    logic [NREQ-1:0]  gnt;
    logic [IDXW-1:0]  gnt_idx;
    logic [CNT_W-1:0] cnt_inc;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // Saturating increment: the tick counter must never wrap back to zero
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and registered-output logic for the IDLE/WAIT/GAP FSM
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_gnt_d    = last_gnt_q;
        tx_din_d      = tx_din_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    ack_d      = gnt;
                    tx_start_d = 1'b1;
                    last_gnt_d = gnt_idx;
                    state_d    = WAIT;
                    cnt_d      = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            tx_din_d = req_data[i*DBIT +: DBIT];
                        end
                    end
                end
            end

            WAIT: begin
                // A done tick coinciding with the final s_tick is a normal
                // completion, so it is tested before the timeout.
                if (tx_done_tick) begin
                    state_d = DONE_NEXT;
                    cnt_d   = '0;
                end else if (s_tick) begin
                    if (cnt_inc >= CNT_W'(TIMEOUT_TICKS)) begin
                        err_timeout_d = 1'b1;
                        state_d       = DONE_NEXT;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            GAP: begin
                if (s_tick) begin
                    if (cnt_inc >= CNT_W'(GAP_TICKS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so busy rises together with tx_start
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_gnt_q    <= IDXW'(NREQ - 1);
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_din_q      <= '0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of the
            // order statements or always blocks are evaluated in.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_gnt_q    <= last_gnt_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_din_q      <= tx_din_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_din      = tx_din_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of single-frame grants,
// then hand-written sequences for GAP priority, timeout, async reset and a
// zero-gap build.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tick;
    logic        tx_done_tick;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        busy;
    logic        err_timeout;

    // Second instance built with no inter-frame gap
    logic        s_tick_z;
    logic        tx_done_z;
    logic [3:0]  req_z;
    logic [31:0] req_data_z;
    logic [3:0]  ack_z;
    logic        tx_start_z;
    logic [7:0]  tx_din_z;
    logic        busy_z;
    logic        err_z;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] din;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  ack;
        logic [7:0]  din;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(4), .DBIT(8), .GAP_TICKS(16), .TIMEOUT_TICKS(320)
    ) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .req(req), .req_data(req_data),
        .ack(ack), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
        .busy(busy), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(
        .NREQ(4), .DBIT(8), .GAP_TICKS(0), .TIMEOUT_TICKS(320)
    ) dut_z (
        .clk(clk), .reset(reset), .s_tick(s_tick_z), .req(req_z), .req_data(req_data_z),
        .ack(ack_z), .tx_start(tx_start_z), .tx_din(tx_din_z), .tx_done_tick(tx_done_z),
        .busy(busy_z), .err_timeout(err_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for tx_start, compare against the scoreboard head and
    // drop the acknowledged request bit
    task automatic expect_grant(input int max_cycles, input int exp_lat);
        int   n;
        logic found;
        exp_t e;
        n     = 0;
        found = 1'b0;
        while (!found && n < max_cycles) begin
            tick();
            n++;
            if (tx_start) found = 1'b1;
        end
        check("grant_seen", found, 1'b1);
        if (found) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                check("ack", ack, e.ack);
                check("tx_din", tx_din, e.din);
            end
            check("latency", n, exp_lat);
            check("busy_on_start", busy, 1'b1);
            req = req & ~ack;
        end
    endtask

    // A few s_ticks in WAIT, then the transmitter's done pulse
    task automatic send_done();
        for (int k = 0; k < 3; k++) begin
            s_tick = 1'b1; tick(); s_tick = 1'b0; tick();
        end
        tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
        check("busy_in_gap", busy, 1'b1);
        check("no_err_on_done", err_timeout, 1'b0);
    endtask

    // Sixteen s_ticks of gap; IDLE must follow the 16th exactly
    task automatic gap_wait();
        logic extra;
        extra = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            s_tick = 1'b1; tick(); s_tick = 1'b0;
            if (tx_start) extra = 1'b1;
            if (k == 15) check("busy_gap15", busy, 1'b1);
            if (k < 16) begin
                tick();
                if (tx_start) extra = 1'b1;
            end
        end
        check("idle_after_gap", busy, 1'b0);
        check("no_start_in_gap", extra, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 4'h0);
        check({tag, "_start"}, tx_start, 1'b0);
        check({tag, "_din"}, tx_din, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        int err_at;

        vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
        vecs[1] = '{4'b1111, 32'h23222120, 4'b0010, 8'h21};
        vecs[2] = '{4'b1111, 32'h33323130, 4'b0100, 8'h32};
        vecs[3] = '{4'b1111, 32'h43424140, 4'b1000, 8'h43};
        vecs[4] = '{4'b1111, 32'h53525150, 4'b0001, 8'h50};
        vecs[5] = '{4'b1001, 32'h63626160, 4'b1000, 8'h63};
        vecs[6] = '{4'b1001, 32'h73727170, 4'b0001, 8'h70};
        vecs[7] = '{4'b0110, 32'h83828180, 4'b0010, 8'h81};
        vecs[8] = '{4'b0101, 32'h93929190, 4'b0100, 8'h92};
        vecs[9] = '{4'b0011, 32'hA3A2A1A0, 4'b0001, 8'hA0};

        reset = 1'b1; s_tick = 1'b0; tx_done_tick = 1'b0; req = '0; req_data = '0;
        s_tick_z = 1'b0; tx_done_z = 1'b0; req_z = '0; req_data_z = '0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_after_reset", busy, 1'b0);

        // Table: one frame per record, requests dropped after ack
        for (int v = 0; v < 10; v++) begin
            req      = vecs[v].req;
            req_data = vecs[v].data;
            sb.push_back({vecs[v].ack, vecs[v].din});
            expect_grant(8, 1);
            req      = '0;
            req_data = ~vecs[v].data;
            tick();
            check("ack_fall", ack, 4'h0);
            check("start_fall", tx_start, 1'b0);
            check("din_hold", tx_din, vecs[v].din);
            send_done();
            gap_wait();
        end

        // Requests raised during GAP: 2 wins ahead of 3 and 0 after grant 1
        req = 4'b0010; req_data = 32'h00005A00;
        sb.push_back({4'b0010, 8'h5A});
        expect_grant(8, 1);
        send_done();
        req = 4'b1101; req_data = 32'h9D7C006B;
        sb.push_back({4'b0100, 8'h7C});
        sb.push_back({4'b1000, 8'h9D});
        sb.push_back({4'b0001, 8'h6B});
        gap_wait();
        expect_grant(8, 1);
        send_done(); gap_wait();
        expect_grant(8, 1);
        send_done(); gap_wait();
        expect_grant(8, 1);
        check("req_all_served", req, 4'h0);
        send_done(); gap_wait();

        // Timeout: 320 s_ticks with no done tick
        req = 4'b0010; req_data = 32'h00001100;
        sb.push_back({4'b0010, 8'h11});
        expect_grant(8, 1);
        errs = 0; err_at = 0;
        for (int k = 1; k <= 320; k++) begin
            s_tick = 1'b1; tick(); s_tick = 1'b0;
            if (err_timeout) begin errs++; err_at = k; end
            tick();
            if (err_timeout) errs++;
        end
        check("timeout_pulses", errs, 1);
        check("timeout_at_tick", err_at, 320);
        check("timeout_to_gap", busy, 1'b1);
        gap_wait();

        // Done tick coinciding with the 320th s_tick: no error
        req = 4'b0100; req_data = 32'h00220000;
        sb.push_back({4'b0100, 8'h22});
        expect_grant(8, 1);
        errs = 0;
        for (int k = 1; k < 320; k++) begin
            s_tick = 1'b1; tick(); s_tick = 1'b0;
            if (err_timeout) errs++;
            tick();
            if (err_timeout) errs++;
        end
        s_tick = 1'b1; tx_done_tick = 1'b1; tick(); s_tick = 1'b0; tx_done_tick = 1'b0;
        if (err_timeout) errs++;
        tick();
        if (err_timeout) errs++;
        check("coincide_no_err", errs, 0);
        check("coincide_to_gap", busy, 1'b1);
        gap_wait();

        // Async reset mid-WAIT
        req = 4'b1000; req_data = 32'h44332211;
        sb.push_back({4'b1000, 8'h44});
        expect_grant(8, 1);
        s_tick = 1'b1; tick(); s_tick = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("rst_wait");
        @(posedge clk); #1 reset = 1'b0;
        tick();
        check("no_ack_abandoned", ack, 4'h0);
        check("idle_after_rst_wait", busy, 1'b0);
        req = 4'b0100; req_data = 32'h00EE0000;
        sb.push_back({4'b0100, 8'hEE});
        expect_grant(8, 1);
        send_done(); gap_wait();

        // Async reset mid-GAP, then last_gnt must be back at 3
        req = 4'b0001; req_data = 32'h000000BB;
        sb.push_back({4'b0001, 8'hBB});
        expect_grant(8, 1);
        send_done();
        for (int k = 0; k < 3; k++) begin
            s_tick = 1'b1; tick(); s_tick = 1'b0; tick();
        end
        #2 reset = 1'b1;
        #1 check_all_zero("rst_gap");
        @(posedge clk); #1 reset = 1'b0;
        tick();
        req = 4'b0101; req_data = 32'h00CC00DD;
        sb.push_back({4'b0001, 8'hDD});
        expect_grant(8, 1);
        req = '0;
        send_done(); gap_wait();

        // Zero-gap build: done -> IDLE next edge, pending grant one cycle later
        req_z = 4'b0011; req_data_z = 32'h0000C3B2;
        tick();
        check("z_start0", tx_start_z, 1'b1);
        check("z_ack0", ack_z, 4'b0001);
        check("z_din0", tx_din_z, 8'hB2);
        req_z = 4'b0010;
        tick();
        tx_done_z = 1'b1; tick(); tx_done_z = 1'b0;
        check("z_idle_after_done", busy_z, 1'b0);
        check("z_no_start_yet", tx_start_z, 1'b0);
        tick();
        check("z_start1", tx_start_z, 1'b1);
        check("z_ack1", ack_z, 4'b0010);
        check("z_din1", tx_din_z, 8'hC3);
        req_z = '0;

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NREQ byte producers using round-robin arbitration.
- Accepts a byte from the granted requester and pulses the transmitter start.
- Waits for the transmitter's done tick, then holds an inter-frame gap counted in baud-generator oversample ticks.
- Sits between the producers (command/response logic) and the UART TX, which is paced by the BRG tick.

Parameters:
NREQ, 4, number of requesters (>=2)
DBIT, 8, data bits per frame
GAP_TICKS, 16, s_tick pulses of idle between frames (0 = no gap)
TIMEOUT_TICKS, 320, s_tick pulses allowed in WAIT before abort (2 frames at 16x oversample, 10 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tick  in  1  BRG oversample tick, one clk wide
req  in  NREQ  request level per requester, held until acked
req_data  in  NREQ*DBIT  byte i at bits [i*DBIT +: DBIT]
ack  out  NREQ  one-cycle pulse, one-hot: byte i accepted
tx_start  out  1  one-cycle start pulse to UART TX
tx_din  out  DBIT  byte to transmit, stable from tx_start until next grant
tx_done_tick  in  1  UART TX end-of-stop-bit pulse
busy  out  1  high whenever state != IDLE
err_timeout  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset (async, any state):
  - state=IDLE; ack=0, tx_start=0, tx_din=0, busy=0, err_timeout=0.
  - Counters cleared; last_gnt=NREQ-1, so req[0] wins first.
  - A frame in flight is abandoned. No ack is issued for it.
- States: IDLE, WAIT, GAP. All outputs registered.
- IDLE, req!=0 at edge N:
  - Winner g is the first set bit scanning last_gnt+1, last_gnt+2, ... (mod NREQ).
  - After edge N: ack[g]=1, tx_start=1, tx_din=req_data[g], last_gnt=g, state=WAIT, tick counter=0.
  - Latency is 1 cycle from the sampled req to ack and tx_start.
  - ack and tx_start fall after edge N+1.
  - Requesters drop req[g] on ack or present the next byte. A req still high after ack is a new request.
- IDLE, req==0: hold state. tx_done_tick and s_tick are ignored.
- WAIT:
  - On tx_done_tick: go to GAP with counter=0, or to IDLE if GAP_TICKS==0.
  - Each s_tick increments the counter. When the counter reaches TIMEOUT_TICKS without tx_done_tick: err_timeout pulses 1 cycle, then handle as done (GAP or IDLE).
  - Simultaneous tx_done_tick and final s_tick: done wins, no err_timeout.
- GAP:
  - Each s_tick increments the counter. After the GAP_TICKS-th s_tick the state goes to IDLE on the same edge.
  - New requests are ignored until IDLE.
  - Minimum IDLE dwell is 1 cycle before the next grant.
- Counter width: clog2(max(GAP_TICKS, TIMEOUT_TICKS)+1). The counter saturates and never wraps.
- Mid-operation req changes:
  - A requester withdrawing req before grant loses its turn silently.
  - req_data changes after ack do not affect tx_din.
- busy is high exactly from the cycle tx_start is high through the last GAP cycle.

Decomposition:
- Shared package (uart_pkg):
  - state encoding localparams: IDLE=2'd0, WAIT=2'd1, GAP=2'd2
  - DBIT default
  - clog2 function
- Sub-module rr_pick:
  - Purely combinational round-robin selector.
  - Inputs: req[NREQ], last_gnt.
  - Outputs: gnt one-hot and gnt_idx.
- The top module holds the FSM, counters and output registers.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5 -> next cycle: ack=0001, tx_start=1, tx_din=A5, busy=1. tx_done_tick later -> GAP. After 16 s_tick -> IDLE, busy=0.
- req=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0. Each tx_start is separated by tx_done plus 16 s_ticks.
- last_gnt=1, req=4'b1001 -> grant 3, then 0 (wrap-around). req[2] rising during GAP -> granted next, ahead of 0.
- No tx_done_tick, 320 s_ticks in WAIT -> err_timeout single pulse, GAP entered. tx_done_tick coinciding with the 320th s_tick -> no err_timeout.
- Reset asserted mid-WAIT and mid-GAP -> all outputs 0 immediately (async). After release, req=4'b0100 -> ack=0100 (last_gnt reset to 3, scan starts at 0).
- GAP_TICKS=0 build: tx_done_tick -> IDLE next edge. Pending req granted one cycle later.
